// File: rtl/agc_att_req_sched_if.sv
// Requester/monitor side and RF-pin side of the shared step-attenuator scheduler.
interface agc_att_req_sched_if;
    logic [2:0]  i_req;
    logic [20:0] i_delta;
    logic [5:0]  i_max_att;
    logic        i_mcu_clr;
    logic [2:0]  o_ack;
    logic        o_pe_data;
    logic        o_pe_clk;
    logic        o_pe_le;
    logic [5:0]  o_att_value;
    logic        o_clamped;
    logic        o_busy;

    modport slave (
        input  i_req, i_delta, i_max_att, i_mcu_clr,
        output o_ack, o_pe_data, o_pe_clk, o_pe_le, o_att_value, o_clamped, o_busy
    );

    modport master (
        output i_req, i_delta, i_max_att, i_mcu_clr,
        input  o_ack, o_pe_data, o_pe_clk, o_pe_le, o_att_value, o_clamped, o_busy
    );
endinterface

// File: rtl/agc_att_req_sched.sv
// Round-robin scheduler sharing one 6-bit serial step attenuator between three gain requesters.
// Applies clamped signed deltas, shifts the frame out MSB first, latches, then waits out the settle time.
module agc_att_req_sched #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned HOLDOFF = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst,
    agc_att_req_sched_if.slave bus
);
    localparam int unsigned BIT_LEN = 2 * CLK_DIV;
    localparam int unsigned CNT_MAX = (HOLDOFF > BIT_LEN) ? HOLDOFF : BIT_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned ATT_W   = 6;
    localparam int unsigned DLT_W   = 7;

    typedef enum logic [2:0] {
        ST_INIT, ST_SHIFT, ST_LATCH, ST_HOLD, ST_IDLE, ST_GRANT, ST_CALC
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         bit_q;
    logic [ATT_W-1:0]   sr_q;
    logic [ATT_W-1:0]   tgt_q;
    logic [ATT_W-1:0]   att_q;
    logic [1:0]         rr_q;
    logic [1:0]         sel_q;
    logic [DLT_W-1:0]   delta_q;
    logic               clr_pend_q;
    logic [2:0]         ack_q;
    logic               data_q;
    logic               pclk_q;
    logic               le_q;
    logic               clamped_q;
    logic               busy_q;

    logic [1:0]         sel_d;
    logic               any_req_d;
    logic [2:0]         idx_d;
    logic [DLT_W-1:0]   delta_d;
    logic signed [7:0]  sum_d;
    logic signed [7:0]  max_d;
    logic [ATT_W-1:0]   tgt_d;
    logic               clamp_d;

    // First active requester at or after rr_q; lowest offset wins.
    always_comb begin
        sel_d     = rr_q;
        any_req_d = 1'b0;
        idx_d     = '0;
        for (int k = 2; k >= 0; k--) begin
            idx_d = 3'(rr_q) + 3'(k);
            if (idx_d >= 3'd3) idx_d = idx_d - 3'd3;
            if (bus.i_req[2'(idx_d)]) begin
                sel_d     = 2'(idx_d);
                any_req_d = 1'b1;
            end
        end
    end

    always_comb begin
        delta_d = bus.i_delta[6:0];
        case (sel_d)
            2'd1:    delta_d = bus.i_delta[13:7];
            2'd2:    delta_d = bus.i_delta[20:14];
            default: delta_d = bus.i_delta[6:0];
        endcase
    end

    // Signed 8-bit sum of held attenuation and delta, clamped to [0, i_max_att].
    always_comb begin
        sum_d   = $signed({2'b00, att_q}) + $signed({delta_q[DLT_W-1], delta_q});
        max_d   = $signed({2'b00, bus.i_max_att});
        tgt_d   = sum_d[ATT_W-1:0];
        clamp_d = 1'b0;
        if (sum_d < 8'sd0) begin
            tgt_d   = '0;
            clamp_d = 1'b1;
        end else if (sum_d > max_d) begin
            tgt_d   = bus.i_max_att;
            clamp_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            bit_q      <= '0;
            sr_q       <= '0;
            tgt_q      <= '0;
            att_q      <= '0;
            rr_q       <= '0;
            sel_q      <= '0;
            delta_q    <= '0;
            clr_pend_q <= 1'b0;
            ack_q      <= '0;
            data_q     <= 1'b0;
            pclk_q     <= 1'b0;
            le_q       <= 1'b0;
            clamped_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ack_q     <= '0;
            clamped_q <= 1'b0;
            if (bus.i_mcu_clr && state_q != ST_IDLE) clr_pend_q <= 1'b1;

            case (state_q)
                ST_INIT: begin
                    tgt_q   <= '0;
                    sr_q    <= '0;
                    data_q  <= 1'b0;
                    pclk_q  <= 1'b0;
                    cnt_q   <= '0;
                    bit_q   <= 3'd5;
                    busy_q  <= 1'b1;
                    state_q <= ST_SHIFT;
                end
                ST_IDLE: begin
                    if (clr_pend_q || bus.i_mcu_clr) begin
                        clr_pend_q <= 1'b0;
                        tgt_q      <= '0;
                        sr_q       <= '0;
                        data_q     <= 1'b0;
                        pclk_q     <= 1'b0;
                        cnt_q      <= '0;
                        bit_q      <= 3'd5;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end else if (any_req_d) begin
                        sel_q   <= sel_d;
                        delta_q <= delta_d;
                        ack_q   <= 3'b001 << sel_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    rr_q    <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    clamped_q <= clamp_d;
                    if (tgt_d == att_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        tgt_q   <= tgt_d;
                        sr_q    <= tgt_d;
                        data_q  <= tgt_d[ATT_W-1];
                        pclk_q  <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= 3'd5;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == CNT_W'(BIT_LEN - 1)) begin
                        cnt_q  <= '0;
                        pclk_q <= 1'b0;
                        if (bit_q == 3'd0) begin
                            data_q  <= 1'b0;
                            le_q    <= 1'b1;
                            att_q   <= tgt_q;
                            state_q <= ST_LATCH;
                        end else begin
                            bit_q  <= bit_q - 3'd1;
                            data_q <= sr_q[ATT_W-2];
                            sr_q   <= {sr_q[ATT_W-2:0], 1'b0};
                        end
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        pclk_q <= (cnt_q >= CNT_W'(CLK_DIV - 1));
                    end
                end
                ST_LATCH: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        le_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign bus.o_ack       = ack_q;
    assign bus.o_pe_data   = data_q;
    assign bus.o_pe_clk    = pclk_q;
    assign bus.o_pe_le     = le_q;
    assign bus.o_att_value = att_q;
    assign bus.o_clamped   = clamped_q;
    assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_agc_att_req_sched.sv
// Directed bench for the attenuator scheduler: stimulus queues expected acks/frames,
// a negedge monitor deserialises the pins and checks each ack and LE pulse against them.
module tb_agc_att_req_sched;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned HOLDOFF = 1024;
    localparam int LAT_LE  = 2 + 12 * CLK_DIV;
    localparam int GAP     = CLK_DIV + HOLDOFF + 1;
    localparam int BUDGET  = 5000;

    typedef struct {
        logic [5:0] val;
        bit         clamp;
        bit         acked;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    frame_t exp_fr_q[$];
    int     exp_ack_q[$];
    int     le_rise_cyc = 0;
    int     ack_cyc = 0;

    agc_att_req_sched_if bus();

    agc_att_req_sched #(.CLK_DIV(CLK_DIV), .HOLDOFF(HOLDOFF)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: pin-level observation, all samples on the falling edge.
    logic       prev_pclk = 1'b0;
    logic       prev_le   = 1'b0;
    logic [2:0] prev_ack  = 3'b000;
    logic [5:0] shreg     = 6'd0;
    int         nbits     = 0;
    int         le_len    = 0;
    int         clamp_cnt = 0;
    bit         acked_seen = 1'b0;
    int         exp_sel;
    frame_t     f;

    always @(negedge clk) begin
        if (rst) begin
            prev_pclk  = 1'b0;
            prev_le    = 1'b0;
            prev_ack   = 3'b000;
            nbits      = 0;
            le_len     = 0;
            clamp_cnt  = 0;
            acked_seen = 1'b0;
        end else begin
            if (bus.o_ack != 3'b000) begin
                check("ack_width", int'(prev_ack != 3'b000), 0);
                check("ack_onehot", int'($onehot(bus.o_ack)), 1);
                check("ack_expected", int'(exp_ack_q.size() != 0), 1);
                if (exp_ack_q.size() != 0) begin
                    exp_sel = exp_ack_q.pop_front();
                    check("ack_sel", int'(bus.o_ack), 1 << exp_sel);
                end
                ack_cyc    = cyc;
                acked_seen = 1'b1;
                clamp_cnt  = 0;
            end
            if (bus.o_clamped) clamp_cnt++;
            if (bus.o_pe_clk && !prev_pclk) begin
                shreg = {shreg[4:0], bus.o_pe_data};
                nbits++;
            end
            if (bus.o_pe_le) le_len++;
            if (bus.o_pe_le && !prev_le) begin
                le_rise_cyc = cyc;
                check("le_clk_low", int'(bus.o_pe_clk), 0);
                check("frame_expected", int'(exp_fr_q.size() != 0), 1);
                if (exp_fr_q.size() != 0) begin
                    f = exp_fr_q.pop_front();
                    check("frame_bits", nbits, 6);
                    check("frame_data", int'(shreg), int'(f.val));
                    check("att_value", int'(bus.o_att_value), int'(f.val));
                    check("clamped", clamp_cnt, int'(f.clamp));
                    check("acked", int'(acked_seen), int'(f.acked));
                    if (f.acked) check("ack_to_le", cyc - ack_cyc, LAT_LE);
                end
                nbits      = 0;
                clamp_cnt  = 0;
                acked_seen = 1'b0;
            end
            if (!bus.o_pe_le && prev_le) begin
                check("le_width", le_len, int'(CLK_DIV));
                le_len = 0;
            end
            prev_pclk = bus.o_pe_clk;
            prev_le   = bus.o_pe_le;
            prev_ack  = bus.o_ack;
        end
    end

    task automatic set_delta(input logic [1:0] sel, input int d);
        logic [6:0] v;
        v = 7'(d);
        case (sel)
            2'd0:    bus.i_delta[6:0]   = v;
            2'd1:    bus.i_delta[13:7]  = v;
            default: bus.i_delta[20:14] = v;
        endcase
    endtask

    task automatic wait_ack(input logic [1:0] sel);
        int n;
        n = 0;
        while (bus.o_ack[sel] !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("ack_wait", int'(n < BUDGET), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.o_busy !== 1'b0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", int'(n < BUDGET), 1);
    endtask

    task automatic do_grant(input logic [1:0] sel, input int d, input logic [5:0] exp_val,
                            input bit exp_clamp, input bit exp_frame);
        exp_ack_q.push_back(int'(sel));
        if (exp_frame) exp_fr_q.push_back('{val: exp_val, clamp: exp_clamp, acked: 1'b1});
        set_delta(sel, d);
        bus.i_req[sel] = 1'b1;
        wait_ack(sel);
        bus.i_req[sel] = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_req     = 3'b000;
        bus.i_delta   = '0;
        bus.i_max_att = 6'd63;
        bus.i_mcu_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", int'(bus.o_ack), 0);
        check("rst_pins", int'({bus.o_pe_data, bus.o_pe_clk, bus.o_pe_le}), 0);
        check("rst_att", int'(bus.o_att_value), 0);
        check("rst_flags", int'({bus.o_clamped, bus.o_busy}), 0);

        // INIT frame of 0, then the first grant only after the full hold-off
        exp_fr_q.push_back('{val: 6'd0, clamp: 1'b0, acked: 1'b0});
        rst = 1'b0;
        do_grant(2'd0, 6, 6'd6, 1'b0, 1'b1);
        check("hold_gap", cyc - le_rise_cyc, GAP);
        wait_idle();

        // clamp high, clamp low
        do_grant(2'd0, 54, 6'd60, 1'b0, 1'b1);
        wait_idle();
        do_grant(2'd1, 10, 6'd63, 1'b1, 1'b1);
        wait_idle();
        do_grant(2'd2, -60, 6'd3, 1'b0, 1'b1);
        wait_idle();
        do_grant(2'd2, -8, 6'd0, 1'b1, 1'b1);
        wait_idle();

        // all three held with rr_ptr=0: order 0,1,2,0
        exp_ack_q.push_back(0); exp_ack_q.push_back(1);
        exp_ack_q.push_back(2); exp_ack_q.push_back(0);
        exp_fr_q.push_back('{val: 6'd1, clamp: 1'b0, acked: 1'b1});
        exp_fr_q.push_back('{val: 6'd3, clamp: 1'b0, acked: 1'b1});
        exp_fr_q.push_back('{val: 6'd6, clamp: 1'b0, acked: 1'b1});
        exp_fr_q.push_back('{val: 6'd7, clamp: 1'b0, acked: 1'b1});
        set_delta(2'd0, 1); set_delta(2'd1, 2); set_delta(2'd2, 3);
        bus.i_req = 3'b111;
        wait_ack(2'd0); wait_ack(2'd1); wait_ack(2'd2); wait_ack(2'd0);
        bus.i_req = 3'b000;
        wait_idle();

        // clear from IDLE
        exp_fr_q.push_back('{val: 6'd0, clamp: 1'b0, acked: 1'b0});
        bus.i_mcu_clr = 1'b1;
        @(negedge clk);
        bus.i_mcu_clr = 1'b0;
        wait_idle();

        // clear during bit 3 of a +5 frame; pending clear beats the queued request 1
        do_grant(2'd0, 5, 6'd5, 1'b0, 1'b1);
        exp_fr_q.push_back('{val: 6'd0, clamp: 1'b0, acked: 1'b0});
        repeat (28) @(negedge clk);
        bus.i_mcu_clr = 1'b1;
        @(negedge clk);
        bus.i_mcu_clr = 1'b0;
        do_grant(2'd1, 4, 6'd4, 1'b0, 1'b1);
        wait_idle();

        // zero delta: no frame, back to IDLE two cycles after ack
        do_grant(2'd0, 6, 6'd10, 1'b0, 1'b1);
        wait_idle();
        do_grant(2'd0, 0, 6'd10, 1'b0, 1'b0);
        @(negedge clk);
        check("busy_calc", int'(bus.o_busy), 1);
        @(negedge clk);
        check("busy_zero_delta", int'(bus.o_busy), 0);
        repeat (60) @(negedge clk);
        check("att_after_zero", int'(bus.o_att_value), 10);

        // lowered max with zero delta still reloads and clamps
        bus.i_max_att = 6'd8;
        do_grant(2'd0, 0, 6'd8, 1'b1, 1'b1);
        wait_idle();

        repeat (5) @(negedge clk);
        check("ack_q_empty", exp_ack_q.size(), 0);
        check("frame_q_empty", exp_fr_q.size(), 0);
        check("final_att", int'(bus.o_att_value), 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
